// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble statistics counter enabled by defining ID_EX_HAZARD_STATS_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rd1_D,
    input  logic [DATA_W-1:0] rd2_D,
    input  logic [DATA_W-1:0] imm_D,
    input  logic [ADDR_W-1:0] rs_D,
    input  logic [ADDR_W-1:0] rt_D,
    input  logic [ADDR_W-1:0] rd_D,
    input  logic              RegWrite_D,
    input  logic              MemtoReg_D,
    input  logic              MemWrite_D,
    input  logic              ALUSrc_D,
    input  logic              RegDst_D,
    input  logic [2:0]        ALUControl_D,
    input  logic              valid_D,
    input  logic              flush_E,
    input  logic              hold_E,
    output logic [DATA_W-1:0] rd1_E,
    output logic [DATA_W-1:0] rd2_E,
    output logic [DATA_W-1:0] imm_E,
    output logic [ADDR_W-1:0] rs_E,
    output logic [ADDR_W-1:0] rt_E,
    output logic [ADDR_W-1:0] rd_E,
    output logic              RegWrite_E,
    output logic              MemtoReg_E,
    output logic              MemWrite_E,
    output logic              ALUSrc_E,
    output logic              RegDst_E,
    output logic [2:0]        ALUControl_E,
    output logic              valid_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic [31:0]       bubble_count
);

    logic lwstall;
    logic load_bubble;

    // A load in EX whose destination is a source of the ID instruction cannot be forwarded in time.
    assign lwstall = valid_E & MemtoReg_E & RegWrite_E & (rt_E != '0)
                   & ((rt_E == rs_D) | (rt_E == rt_D)) & valid_D;

    assign load_bubble = flush_E | lwstall;
    assign stall_F     = lwstall | hold_E;
    assign stall_D     = lwstall | hold_E;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_E        <= '0;
            rd2_E        <= '0;
            imm_E        <= '0;
            rs_E         <= '0;
            rt_E         <= '0;
            rd_E         <= '0;
            RegWrite_E   <= 1'b0;
            MemtoReg_E   <= 1'b0;
            MemWrite_E   <= 1'b0;
            ALUSrc_E     <= 1'b0;
            RegDst_E     <= 1'b0;
            ALUControl_E <= '0;
            valid_E      <= 1'b0;
        end else if (!hold_E) begin
            if (load_bubble) begin
                rd1_E        <= '0;
                rd2_E        <= '0;
                imm_E        <= '0;
                rs_E         <= '0;
                rt_E         <= '0;
                rd_E         <= '0;
                RegWrite_E   <= 1'b0;
                MemtoReg_E   <= 1'b0;
                MemWrite_E   <= 1'b0;
                ALUSrc_E     <= 1'b0;
                RegDst_E     <= 1'b0;
                ALUControl_E <= '0;
                valid_E      <= 1'b0;
            end else begin
                rd1_E        <= rd1_D;
                rd2_E        <= rd2_D;
                imm_E        <= imm_D;
                rs_E         <= rs_D;
                rt_E         <= rt_D;
                rd_E         <= rd_D;
                RegWrite_E   <= RegWrite_D;
                MemtoReg_E   <= MemtoReg_D;
                MemWrite_E   <= MemWrite_D;
                ALUSrc_E     <= ALUSrc_D;
                RegDst_E     <= RegDst_D;
                ALUControl_E <= ALUControl_D;
                valid_E      <= valid_D;
            end
        end
    end

`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (!hold_E && load_bubble)
            bubble_cnt <= bubble_cnt + 32'd1;
    end

    assign bubble_count = bubble_cnt;
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/hold/reset cases plus
// randomized traffic compared every cycle against a behavioural pipeline model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mtr;
        logic        mw;
        logic        as;
        logic        rdst;
        logic [2:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
    } stage_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    stage_t      d = '0;
    stage_t      m = '0;
    logic [31:0] m_cnt = '0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] rd1_E, rd2_E, imm_E, bubble_count;
    logic [4:0]  rs_E, rt_E, rd_E;
    logic        RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E, valid_E;
    logic [2:0]  ALUControl_E;
    logic        stall_F, stall_D;
    stage_t      act;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .rd1_D(d.rd1), .rd2_D(d.rd2), .imm_D(d.imm),
        .rs_D(d.rs), .rt_D(d.rt), .rd_D(d.rd),
        .RegWrite_D(d.rw), .MemtoReg_D(d.mtr), .MemWrite_D(d.mw),
        .ALUSrc_D(d.as), .RegDst_D(d.rdst), .ALUControl_D(d.alu),
        .valid_D(d.v), .flush_E(flush), .hold_E(hold),
        .rd1_E(rd1_E), .rd2_E(rd2_E), .imm_E(imm_E),
        .rs_E(rs_E), .rt_E(rt_E), .rd_E(rd_E),
        .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .MemWrite_E(MemWrite_E),
        .ALUSrc_E(ALUSrc_E), .RegDst_E(RegDst_E), .ALUControl_E(ALUControl_E),
        .valid_E(valid_E), .stall_F(stall_F), .stall_D(stall_D),
        .bubble_count(bubble_count)
    );

    assign act = {valid_E, RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E,
                  ALUControl_E, rs_E, rt_E, rd_E, rd1_E, rd2_E, imm_E};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic model_lwstall();
        return m.v && m.mtr && m.rw && (m.rt != 5'd0) && ((m.rt == d.rs) || (m.rt == d.rt)) && d.v;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef ID_EX_HAZARD_STATS_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    // Model update at the active edge: hold freezes, flush/lwstall loads a bubble, else copy.
    task automatic model_edge();
        if (!hold) begin
            if (flush || model_lwstall()) begin
                m = '0;
                m_cnt = m_cnt + 32'd1;
            end else begin
                m = d;
            end
        end
    endtask

    task automatic check_all();
        chk("e_regs", act, m);
        chk("stall_F", stall_F, model_lwstall() | hold);
        chk("stall_D", stall_D, model_lwstall() | hold);
        chk("bubble_count", bubble_count, exp_count());
    endtask

    // Called with clk low; inputs already driven.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    function automatic stage_t rand_d();
        stage_t r;
        r.v    = ($urandom_range(0, 9) != 0);
        r.rw   = $urandom_range(0, 1);
        r.mtr  = $urandom_range(0, 1);
        r.mw   = $urandom_range(0, 1);
        r.as   = $urandom_range(0, 1);
        r.rdst = $urandom_range(0, 1);
        r.alu  = 3'($urandom_range(0, 7));
        r.rs   = 5'($urandom_range(0, 3));
        r.rt   = 5'($urandom_range(0, 3));
        r.rd   = 5'($urandom_range(0, 31));
        r.rd1  = $urandom;
        r.rd2  = $urandom;
        r.imm  = $urandom;
        return r;
    endfunction

    function automatic stage_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic rw, input logic mtr, input logic mw);
        stage_t r;
        r = rand_d();
        r.v = 1'b1; r.rs = rs; r.rt = rt; r.rw = rw; r.mtr = mtr; r.mw = mw;
        return r;
    endfunction

    stage_t snap;
    logic [31:0] cnt_before;

    initial begin
        // Reset with random decode inputs.
        d = rand_d();
        #2;
        chk("rst_e_regs", act, 128'd0);
        chk("rst_stall_F", stall_F, 1'b0);
        chk("rst_bubble_count", bubble_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d = rand_d();
        d.rd1 = 32'h12345678;
        d.rs = 5'd3;
        step();
        chk("first_rd1_E", rd1_E, 32'h12345678);
        chk("first_rs_E", rs_E, 5'd3);

        // Load-use: lw r8 then add using r8.
        d = mk(5'd1, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        d = mk(5'd8, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall_F", stall_F, 1'b1);
        chk("lu_stall_D", stall_D, 1'b1);
        step();
        chk("lu_bubble_valid_E", valid_E, 1'b0);
        chk("lu_bubble_RegWrite_E", RegWrite_E, 1'b0);
`ifdef ID_EX_HAZARD_STATS_EN
        chk("lu_bubble_count", bubble_count, 32'd1);
`else
        chk("lu_bubble_count", bubble_count, 32'd0);
`endif
        step();
        chk("lu_rs_E", rs_E, 5'd8);
        chk("lu_stall_after", stall_F, 1'b0);

        // No false stall: lw to r0, then a non-load writing r8.
        d = mk(5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        d = mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("r0_no_stall", stall_F, 1'b0);
        step();
        d = mk(5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
        d = mk(5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("nonload_no_stall", stall_F, 1'b0);
        step();
        chk("nonload_advanced_valid", valid_E, 1'b1);

        // Flush coincident with load-use: one bubble, count +1.
        d = mk(5'd1, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        cnt_before = bubble_count;
        d = mk(5'd5, 5'd6, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_MemWrite_E", MemWrite_E, 1'b0);
        chk("flush_valid_E", valid_E, 1'b0);
`ifdef ID_EX_HAZARD_STATS_EN
        chk("flush_count_plus1", bubble_count, cnt_before + 32'd1);
`endif

        // Hold for 3 cycles with changing inputs and flush in the second.
        d = mk(5'd9, 5'd10, 1'b1, 1'b0, 1'b1);
        step();
        snap = act;
        cnt_before = bubble_count;
        for (int i = 0; i < 3; i++) begin
            d = rand_d();
            hold = 1'b1;
            flush = (i == 1);
            #1;
            chk("hold_stall_F", stall_F, 1'b1);
            chk("hold_stall_D", stall_D, 1'b1);
            step();
            chk("hold_frozen", act, snap);
            chk("hold_no_bubble", bubble_count, cnt_before);
        end
        hold = 1'b0;
        flush = 1'b0;

        // Asynchronous reset in the middle of a stall.
        d = mk(5'd1, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        d = mk(5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
        #2;
        chk("pre_rst_stall", stall_F, 1'b1);
        rst = 1'b1;
        #1;
        m = '0;
        m_cnt = '0;
        chk("midrst_e_regs", act, 128'd0);
        chk("midrst_stall", stall_F, 1'b0);
        chk("midrst_count", bubble_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_load_rs_E", rs_E, 5'd7);

`ifdef ID_EX_HAZARD_STATS_EN
        // Counter wrap.
        force dut.bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt;
        m_cnt = 32'hFFFF_FFFF;
        d = rand_d();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("wrap_count", bubble_count, 32'd0);
`endif

        // Randomized traffic with frequent address collisions.
        for (int i = 0; i < 600; i++) begin
            d = rand_d();
            hold = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        hold = 1'b0;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule
